// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings and state type for the ALU op sequencer
package alu_seq_pkg;

  localparam int WIDTH_DEFAULT = 16;

  // Requester command encodings (110/111 are invalid)
  localparam logic [2:0] CMD_AND = 3'b000;
  localparam logic [2:0] CMD_OR  = 3'b001;
  localparam logic [2:0] CMD_XOR = 3'b010;
  localparam logic [2:0] CMD_ADD = 3'b011;
  localparam logic [2:0] CMD_SUB = 3'b100;
  localparam logic [2:0] CMD_MUL = 3'b101;

  // ALU function-select encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True for commands whose carry flag comes from the adder
  function automatic logic is_arith(input logic [2:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle controller sequencing a shared ALU for one requester
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Cmd,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic             AluBInvert,
  output logic             AluCIN,
  output logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluCarry
);

  state_e           state;
  logic [2:0]       cmd_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [3:0]       iter;
  logic             sticky;

  // ALU controls are a pure decode of the current state and operand registers,
  // so they are stable for the whole driving cycle and zero outside EXEC/MUL.
  always_comb begin
    AluA       = '0;
    AluB       = '0;
    AluOp      = ALU_AND;
    AluBInvert = 1'b0;
    AluCIN     = 1'b0;
    case (state)
      ST_EXEC: begin
        AluA = a_reg;
        AluB = b_reg;
        case (cmd_reg)
          CMD_AND: AluOp = ALU_AND;
          CMD_OR:  AluOp = ALU_OR;
          CMD_XOR: AluOp = ALU_XOR;
          CMD_ADD: AluOp = ALU_ADD;
          CMD_SUB: begin
            AluOp      = ALU_ADD;
            AluBInvert = 1'b1;
            AluCIN     = 1'b1;
          end
          default: AluOp = ALU_AND;
        endcase
      end
      ST_MUL: begin
        AluOp = ALU_ADD;
        AluA  = acc;
        AluB  = mplier[0] ? mcand : '0;
      end
      default: begin
        AluOp = ALU_AND;
      end
    endcase
  end

  // Control FSM plus operand/accumulator registers; Busy and Done are registered
  // so they change on the same edge as the state they describe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_IDLE;
      cmd_reg  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      iter     <= '0;
      sticky   <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Result   <= '0;
      CarryOut <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            cmd_reg <= Cmd;
            a_reg   <= OpA;
            b_reg   <= OpB;
            Busy    <= 1'b1;
            if (Cmd <= CMD_SUB) begin
              state <= ST_EXEC;
            end else if (Cmd == CMD_MUL) begin
              acc    <= '0;
              mcand  <= OpA;
              mplier <= OpB;
              iter   <= 4'd0;
              sticky <= 1'b0;
              state  <= ST_MUL;
            end else begin
              // Invalid command: complete immediately with a zero result
              Result   <= '0;
              CarryOut <= 1'b0;
              Done     <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end

        ST_EXEC: begin
          Result   <= AluResult;
          CarryOut <= is_arith(cmd_reg) ? AluCarry : 1'b0;
          Done     <= 1'b1;
          state    <= ST_DONE;
        end

        ST_MUL: begin
          acc    <= AluResult;
          sticky <= sticky | AluCarry;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          iter   <= iter + 4'd1;
          // All 16 iterations always run; no early exit on a zero multiplier
          if (iter == 4'd15) begin
            Result   <= AluResult;
            CarryOut <= sticky | AluCarry;
            Done     <= 1'b1;
            state    <= ST_DONE;
          end
        end

        ST_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that owns the control inputs of the shared 16-bit ALU (the array of 1-bit ALU slices) and sequences it on behalf of one requester. Single-cycle commands (AND/OR/XOR/ADD/SUB) pass through in one ALU cycle. MUL is executed as a 16-iteration shift-add loop that reuses the ALU adder. The block sits between the CPU control unit and the ALU instance in the datapath.

## Interface
- `WIDTH`, default 16: operand, result and ALU width. Only the value 16 is verified.
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: request strobe. Sampled only when `Busy`=0.
- `Cmd` in 3: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110/111 invalid.
- `OpA` in WIDTH: first operand.
- `OpB` in WIDTH: second operand.
- `Busy` out 1: high from the cycle after acceptance until `Done` deasserts.
- `Done` out 1: one-cycle pulse. `Result` and `CarryOut` are valid while it is high.
- `Result` out WIDTH: registered result, held until the next `Done`.
- `CarryOut` out 1: registered carry/overflow flag, held the same way as `Result`.
- `AluA` out WIDTH: ALU A input.
- `AluB` out WIDTH: ALU B input.
- `AluBInvert` out 1: ALU B-invert control.
- `AluCIN` out 1: ALU carry-in.
- `AluOp` out 3: ALU function select. 000 AND, 001 OR, 010 XOR, 011 ADD/sum.
- `AluResult` in WIDTH: combinational ALU result.
- `AluCarry` in 1: combinational ALU carry-out.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE, `Start`=1: latch `Cmd`, `OpA`, `OpB`.
  - Cmd 000–100 → EXEC.
  - Cmd 101 → MUL. Clear the accumulator, load multiplicand M←`OpA`, multiplier Q←`OpB`, iteration counter←0.
  - Cmd 110/111 → DONE with `Result`=0, `CarryOut`=0.
- EXEC: drive `AluA`=A_reg, `AluB`=B_reg.
  - AND/OR/XOR: `AluOp`=000/001/010, `AluBInvert`=0, `AluCIN`=0.
  - ADD: `AluOp`=011, `AluBInvert`=0, `AluCIN`=0.
  - SUB: `AluOp`=011, `AluBInvert`=1, `AluCIN`=1.
  - At the end of the cycle capture `Result`←`AluResult`. For ADD/SUB capture `CarryOut`←`AluCarry`; for logic ops `CarryOut`←0. Go to DONE.
- MUL: each cycle drive `AluOp`=011, `AluBInvert`=0, `AluCIN`=0, `AluA`=acc, `AluB`= Q[0] ? M : 0. At the end of the cycle:
  - acc←`AluResult`; sticky carry |= `AluCarry`.
  - M←M<<1, truncated to WIDTH; Q←Q>>1; counter+1.
  - After iteration 15: `Result`←the `AluResult` of that cycle, `CarryOut`←the sticky carry including that cycle. Go to DONE.
- MUL arithmetic rules:
  - The result is the low WIDTH bits of the product.
  - `CarryOut` flags only adder carries. Multiplicand bits shifted out are not counted, so `CarryOut` is not a full overflow indicator.
  - There is no early exit when Q becomes 0; all 16 iterations always run.
- DONE: `Done`=1 → IDLE unconditionally.
- `Start` while `Busy`=1 is ignored; there is no queueing.
- Invalid commands produce no ALU activity.
- Outside EXEC/MUL: `AluA`=0, `AluB`=0, `AluOp`=000, `AluBInvert`=0, `AluCIN`=0.
- The counter is 4 bits wide.

## Timing
- Reset: state IDLE; `Busy`=0, `Done`=0, `Result`=0, `CarryOut`=0; all ALU controls 0; internal registers cleared.
- `Reset` has priority over every transition. Asserting it mid-EXEC or mid-MUL aborts the operation: no `Done`, and `Result`/`CarryOut` return to 0.
- Let edge k be the acceptance edge (IDLE with `Start`=1).
- Single-cycle ops: EXEC in cycle k+1, `Done` in cycle k+2, IDLE in k+3. Latency 2 cycles.
- MUL: MUL state in cycles k+1..k+16, `Done` in k+17. Latency 17 cycles.
- Invalid commands: `Done` in k+1.
- Back-to-back: a `Start` held high in the `Done` cycle is not accepted. The earliest new acceptance is the edge ending the first IDLE cycle after DONE.
- The ALU path is purely combinational within one cycle. `AluResult`/`AluCarry` are sampled at the same edge that ends the driving cycle.

## Structure
- Shared package (`alu_seq_pkg`) holds:
  - `Cmd` encodings;
  - ALU `AluOp` encodings (AND/OR/XOR/ADD);
  - the state enum;
  - `WIDTH_DEFAULT`=16.
- No sub-module is needed; the controller is one FSM plus datapath registers.
- The 16-bit ALU is not instantiated here. The parent connects the `Alu*` ports to it.

## Test plan
- ADD: `OpA`=0xFFFF, `OpB`=0x0001 → `Done` 2 cycles after acceptance, `Result`=0x0000, `CarryOut`=1.
- SUB: `OpA`=0x0005, `OpB`=0x0007 → `AluBInvert`=1 and `AluCIN`=1 during EXEC; `Result`=0xFFFE, `CarryOut`=0.
- MUL: `OpA`=0x0013, `OpB`=0x0021 → `Busy`=1 for 17 cycles, `Done` at k+17, `Result`=0x0273, `CarryOut`=0.
- MUL with carry: `OpA`=0xC000, `OpB`=0x0003 → `Result`=0x4000, `CarryOut`=1.
- `Start` with XOR held high throughout a MUL → ignored; exactly one `Done` with the MUL result. Invalid `Cmd`=111 → `Done` at k+1, `Result`=0.
- `Reset` asserted at iteration 8 of a MUL → next cycle IDLE, all outputs 0, no `Done`. A subsequent OR of 0x00F0 | 0x0F00 returns 0x0FF0.
